led_sequencer: RTL and testbench

//   Parametrised LED pattern generator for the lab board LED bar.

---
 rtl/led_sequencer.sv | 139 +++++++++++++
 tb/tb_led_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED bar pattern generator: BOUNCE / ROT_L / ROT_R / FILL, stepped by a programmable prescaler.
// Optional comet tail is compiled in with `define LED_SEQ_TRAIL_EN.
module led_sequencer #(
  parameter int BITS  = 10,
  parameter int DIV_W = 24,
  parameter int TRAIL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] speed,
  output logic [BITS-1:0]  q_leds,
  output logic             dir_left,
  output logic             step
);

  typedef enum logic [1:0] {
    BOUNCE = 2'b00,
    ROT_L  = 2'b01,
    ROT_R  = 2'b10,
    FILL   = 2'b11
  } mode_e;

  localparam logic [BITS-1:0] ONE_HOT0 = {{(BITS-1){1'b0}}, 1'b1};

  if (BITS < 3 || TRAIL < 1 || TRAIL > BITS - 2) begin : g_bad_params
    $error("led_sequencer: illegal BITS/TRAIL combination");
  end

  mode_e             mode_in;
  mode_e             mode_q, mode_d;
  logic [BITS-1:0]   head_q, head_d;
  logic              dir_q, dir_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              tick;

  assign mode_in = mode_e'(mode);

`ifdef LED_SEQ_TRAIL_EN
  logic [TRAIL-1:0][BITS-1:0] hist_q, hist_d;
  logic [BITS-1:0]            leds_q, leds_d;
  logic [BITS-1:0]            tail;
`endif

  always_comb begin
    head_d = head_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    mode_d = mode_q;
    tick   = 1'b0;
`ifdef LED_SEQ_TRAIL_EN
    hist_d = hist_q;
`endif
    // A mode change restarts from the one-hot start pattern, even while frozen.
    if (mode_in != mode_q) begin
      head_d = ONE_HOT0;
      dir_d  = 1'b1;
      cnt_d  = '0;
      mode_d = mode_in;
`ifdef LED_SEQ_TRAIL_EN
      hist_d = '0;
`endif
    end else if (en) begin
      tick   = (cnt_q >= speed);
      step_d = tick;
      cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) begin
        case (mode_q)
          BOUNCE: begin
            if (dir_q) begin
              head_d = head_q << 1;
              if (head_q[BITS-2]) dir_d = 1'b0;
            end else begin
              head_d = head_q >> 1;
              if (head_q[1]) dir_d = 1'b1;
            end
          end
          ROT_L: begin
            head_d = {head_q[BITS-2:0], head_q[BITS-1]};
            dir_d  = 1'b1;
          end
          ROT_R: begin
            head_d = {head_q[0], head_q[BITS-1:1]};
            dir_d  = 1'b0;
          end
          FILL: begin
            head_d = (head_q == {BITS{1'b1}}) ? ONE_HOT0 : {head_q[BITS-2:0], 1'b1};
            dir_d  = 1'b1;
          end
        endcase
`ifdef LED_SEQ_TRAIL_EN
        hist_d[0] = head_q;
        for (int i = 1; i < TRAIL; i++) hist_d[i] = hist_q[i-1];
`endif
      end
    end
`ifdef LED_SEQ_TRAIL_EN
    tail = '0;
    for (int i = 0; i < TRAIL; i++) tail = tail | hist_d[i];
    leds_d = (mode_d == FILL) ? head_d : (head_d | tail);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= ONE_HOT0;
      dir_q  <= 1'b1;
      cnt_q  <= '0;
      step_q <= 1'b0;
      mode_q <= mode_in;
`ifdef LED_SEQ_TRAIL_EN
      hist_q <= '0;
      leds_q <= ONE_HOT0;
`endif
    end else begin
      head_q <= head_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      mode_q <= mode_d;
`ifdef LED_SEQ_TRAIL_EN
      hist_q <= hist_d;
      leds_q <= leds_d;
`endif
    end
  end

`ifdef LED_SEQ_TRAIL_EN
  assign q_leds = leds_q;
`else
  assign q_leds = head_q;
`endif
  assign dir_left = dir_q;
  assign step     = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed literal checks followed by randomized stimulus against a phase-based model.
module tb_led_sequencer;

  localparam int BITS  = 10;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] speed;
  logic [BITS-1:0]  q_leds;
  logic             dir_left;
  logic             step;

  int total = 0;
  int bad   = 0;

  // Model: the pattern is a function of (mode, phase); phase advances once per tick.
  int       m_mode;
  int       m_ph;
  bit       m_dir;
  longint   m_cnt;
  bit       m_step;

  led_sequencer #(.BITS(BITS), .DIV_W(DIV_W), .TRAIL(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
    .q_leds(q_leds), .dir_left(dir_left), .step(step)
  );

  always #5 clk = ~clk;

  function automatic longint exp_leds();
    int pos;
    case (m_mode)
      0: pos = (m_ph <= BITS - 1) ? m_ph : 2 * (BITS - 1) - m_ph;
      3: return (64'd1 << (m_ph + 1)) - 1;
      default: pos = m_ph;
    endcase
    return 64'd1 << pos;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_restart(input int md);
    m_mode = md; m_ph = 0; m_dir = 1'b1; m_cnt = 0; m_step = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit e, input int md, input longint spd);
    bit tick;
    if (r || md != m_mode) begin
      model_restart(md);
    end else if (!e) begin
      m_step = 1'b0;
    end else begin
      tick   = (m_cnt >= spd);
      m_step = tick;
      m_cnt  = tick ? 0 : m_cnt + 1;
      if (tick) begin
        case (m_mode)
          0: begin
            m_ph  = (m_ph + 1) % (2 * (BITS - 1));
            m_dir = (m_ph < BITS - 1);
          end
          1: begin m_ph = (m_ph + 1) % BITS;        m_dir = 1'b1; end
          2: begin m_ph = (m_ph + BITS - 1) % BITS; m_dir = 1'b0; end
          default: begin m_ph = (m_ph + 1) % BITS;  m_dir = 1'b1; end
        endcase
      end
    end
  endtask

  // One clock: drive on negedge, advance model at posedge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit e, input logic [1:0] md, input logic [DIV_W-1:0] spd);
    @(negedge clk);
    rst = r; en = e; mode = md; speed = spd;
    @(posedge clk);
    model_step(r, e, int'(md), longint'(spd));
    #1;
    chk("q_leds",   longint'(q_leds),   exp_leds());
    chk("dir_left", longint'(dir_left), longint'(m_dir));
    chk("step",     longint'(step),     longint'(m_step));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; speed = '0;
    model_restart(0);

    cyc(1, 0, 2'b00, 0);
    chk("lit_reset_q", longint'(q_leds), 64'h001);
    chk("lit_reset_dir", longint'(dir_left), 1);
    chk("lit_reset_step", longint'(step), 0);

    repeat (9) cyc(0, 1, 2'b00, 0);
    chk("lit_bounce_top_q", longint'(q_leds), 64'h200);
    chk("lit_bounce_top_dir", longint'(dir_left), 0);
    repeat (9) cyc(0, 1, 2'b00, 0);
    chk("lit_bounce_bottom_q", longint'(q_leds), 64'h001);
    chk("lit_bounce_bottom_dir", longint'(dir_left), 1);

    repeat (3) cyc(0, 1, 2'b00, 3);
    chk("lit_prescale_wait", longint'(step), 0);
    cyc(0, 1, 2'b00, 3);
    chk("lit_prescale_step", longint'(step), 1);
    chk("lit_prescale_q", longint'(q_leds), 64'h002);
    repeat (10) cyc(0, 0, 2'b00, 3);
    chk("lit_freeze_q", longint'(q_leds), 64'h002);
    repeat (4) cyc(0, 1, 2'b00, 3);
    chk("lit_resume_q", longint'(q_leds), 64'h004);

    cyc(0, 0, 2'b11, 0);
    chk("lit_modechg_q", longint'(q_leds), 64'h001);
    chk("lit_modechg_step", longint'(step), 0);
    repeat (9) cyc(0, 1, 2'b11, 0);
    chk("lit_fill_full", longint'(q_leds), 64'h3FF);
    cyc(0, 1, 2'b11, 0);
    chk("lit_fill_wrap", longint'(q_leds), 64'h001);

    cyc(0, 1, 2'b10, 0);
    cyc(0, 1, 2'b10, 0);
    chk("lit_rotr_wrap", longint'(q_leds), 64'h200);
    chk("lit_rotr_dir", longint'(dir_left), 0);
    cyc(0, 1, 2'b01, 0);
    repeat (10) cyc(0, 1, 2'b01, 0);
    chk("lit_rotl_period", longint'(q_leds), 64'h001);

    cyc(0, 1, 2'b00, 0);
    repeat (7) cyc(0, 1, 2'b00, 0);
    chk("lit_mid_bounce", longint'(q_leds), 64'h080);
    cyc(1, 1, 2'b00, 0);
    chk("lit_rst_mid_q", longint'(q_leds), 64'h001);

    // Randomized run: sticky mode/speed with occasional changes, enable gaps, rare resets.
    begin
      logic [1:0]       md = 2'b00;
      logic [DIV_W-1:0] spd = '0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) < 2)  md  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 5)  spd = DIV_W'($urandom_range(0, 5));
        cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0), md, spd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
